pcpi_dispatch: RTL and testbench
================================

Name: pcpi_dispatch

Overview:
- Sits between the CPU PCPI master port and two PCPI co-processor slaves: slot 0 is the approximate-multiply core, slot 1 is a second extension core.
- Latches the master request, broadcasts it to both slaves, merges their wait/ready responses and returns a single registered result to the CPU.
- Enforces a no-response timeout and a one-cycle drain so slaves return to idle cleanly between instructions.

Parameters:
- TIMEOUT, 16: cycles a request may stay unclaimed (no slave wait or ready) before it is abandoned. Must be ≥2.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m_valid  in  1  CPU request valid
- m_insn  in  32  CPU instruction word
- m_rs1  in  32  operand 1
- m_rs2  in  32  operand 2
- m_wr  out  1  result write-enable to CPU
- m_rd  out  32  result to CPU
- m_wait  out  1  OR of slave waits, registered
- m_ready  out  1  one-cycle completion pulse
- s_valid  out  1  broadcast valid to both slaves
- s_insn / s_rs1 / s_rs2  out  32 each  latched request, shared by both slaves
- s0_wr, s0_ready, s0_wait  in  1 each  slave 0 handshake
- s0_rd  in  32  slave 0 result
- s1_wr, s1_ready, s1_wait  in  1 each  slave 1 handshake
- s1_rd  in  32  slave 1 result

Behaviour:
- Reset, asynchronous on resetn low: state=IDLE; all outputs 0 (m_wr, m_rd, m_wait, m_ready, s_valid, s_insn, s_rs1, s_rs2); counter=0. Reset mid-operation aborts immediately with no m_ready.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - If m_valid, latch m_insn/m_rs1/m_rs2 into s_*, set s_valid=1 and go to ISSUE.
  - Latching happens only here; operands are frozen while in ISSUE.
- ISSUE:
  - m_wait <= s0_wait | s1_wait.
  - The counter increments each cycle in which neither slave asserts wait or ready. It is cleared on any cycle with a slave wait.
  - On s0_ready: m_rd <= s0_rd, m_wr <= s0_wr, m_ready <= 1.
  - Else on s1_ready: the same using s1_rd/s1_wr.
  - Both ready in the same cycle: slot 0 wins and the slot 1 result is discarded.
  - After any ready, go to DRAIN.
  - If counter reaches TIMEOUT: no m_ready, m_wr=0, go to DRAIN. The CPU then handles the instruction as illegal.
  - If m_valid drops while in ISSUE (CPU abandoned the request): go to DRAIN, no m_ready.
- DRAIN:
  - s_valid=0, m_wait=0, m_ready=0, m_wr=0, m_rd=0, counter=0.
  - Exactly one cycle, then IDLE.
  - m_valid is ignored during DRAIN, so no re-issue of the retiring request.
- Latency: slave ready in cycle k gives m_ready in cycle k+1. Minimum total latency is 2 cycles, m_valid to s_valid to m_ready.
- m_ready and m_wr are high for exactly one cycle. m_rd is valid only in that cycle and is 0 otherwise.
- s_valid falls in the DRAIN cycle (the cycle after the ready cycle).

Optional Feature:
- Macro: PCPI_DISPATCH_STATS_EN.
- Defined: adds outputs stat_s0 (16), stat_s1 (16), stat_timeout (8) and stat_collide (8):
  - stat_s0 / stat_s1: completions per slot.
  - stat_timeout: timeouts.
  - stat_collide: cycles where both slaves were ready together.
  - All counters saturate, never wrap, and reset to 0.
- Undefined: no counter logic and no stat ports; all other behaviour is identical.

Test Plan:
- s0 model with 4-cycle latency, m_rs1=0x0003, m_rs2=0x0005: m_rd=0x0000000F, m_wr=1 for one cycle, m_ready 1 cycle after s0_ready, DRAIN one cycle, s_valid=0 afterwards.
- Neither slave responds, TIMEOUT=16: no m_ready, m_wr=0, return to IDLE 17 cycles after issue. With stats enabled, stat_timeout=1.
- s0_wait held for 40 cycles, then s0_ready with s0_rd=0x12345678: no timeout, m_wait high throughout, m_rd=0x12345678.
- s0_ready and s1_ready in the same cycle with s0_rd=0xAAAA, s1_rd=0x5555: m_rd=0x0000AAAA. With stats enabled, stat_collide=1 and stat_s0=1.
- m_valid dropped 3 cycles into ISSUE: no m_ready, DRAIN then IDLE. Next request is accepted normally.
- resetn pulsed low mid-ISSUE with s0_wait high: all outputs are 0 within the same cycle (asynchronous), state is IDLE, no m_ready after release.

Source files
------------

// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: latches one CPU request, broadcasts it to two co-processor slots and returns one registered result.
// Optional saturating statistics counters are enabled by defining PCPI_DISPATCH_STATS_EN.
module pcpi_dispatch #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic [31:0] m_insn,
  input  logic [31:0] m_rs1,
  input  logic [31:0] m_rs2,
  output logic        m_wr,
  output logic [31:0] m_rd,
  output logic        m_wait,
  output logic        m_ready,
  output logic        s_valid,
  output logic [31:0] s_insn,
  output logic [31:0] s_rs1,
  output logic [31:0] s_rs2,
  input  logic        s0_wr,
  input  logic        s0_ready,
  input  logic        s0_wait,
  input  logic [31:0] s0_rd,
  input  logic        s1_wr,
  input  logic        s1_ready,
  input  logic        s1_wait,
  input  logic [31:0] s1_rd
`ifdef PCPI_DISPATCH_STATS_EN
  ,
  output logic [15:0] stat_s0,
  output logic [15:0] stat_s1,
  output logic [7:0]  stat_timeout,
  output logic [7:0]  stat_collide
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_s_valid;
  logic [XLEN-1:0]   w_s_insn;
  logic [XLEN-1:0]   w_s_rs1;
  logic [XLEN-1:0]   w_s_rs2;
  logic              w_m_wait;
  logic              w_m_ready;
  logic              w_m_wr;
  logic [XLEN-1:0]   w_m_rd;
  logic              w_any_wait;

  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_any_wait = s0_wait | s1_wait;

  // State, request and response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      s_valid <= 1'b0;
      s_insn  <= '0;
      s_rs1   <= '0;
      s_rs2   <= '0;
      m_wait  <= 1'b0;
      m_ready <= 1'b0;
      m_wr    <= 1'b0;
      m_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      s_valid <= w_s_valid;
      s_insn  <= w_s_insn;
      s_rs1   <= w_s_rs1;
      s_rs2   <= w_s_rs2;
      m_wait  <= w_m_wait;
      m_ready <= w_m_ready;
      m_wr    <= w_m_wr;
      m_rd    <= w_m_rd;
    end
  end

  // Next state; slot 0 wins a simultaneous ready, a ready beats timeout and abandon
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_s_valid   = s_valid;
    w_s_insn    = s_insn;
    w_s_rs1     = s_rs1;
    w_s_rs2     = s_rs2;
    w_m_wait    = 1'b0;
    w_m_ready   = 1'b0;
    w_m_wr      = 1'b0;
    w_m_rd      = '0;
    case (r_state)
      ST_IDLE: begin
        w_s_valid = 1'b0;
        if (m_valid) begin
          w_s_insn    = m_insn;
          w_s_rs1     = m_rs1;
          w_s_rs2     = m_rs2;
          w_s_valid   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_m_wait  = w_any_wait;
        w_cnt_nxt = r_cnt;
        if (s0_ready) begin
          w_m_ready   = 1'b1;
          w_m_wr      = s0_wr;
          w_m_rd      = s0_rd;
          w_state_nxt = ST_DRAIN;
        end else if (s1_ready) begin
          w_m_ready   = 1'b1;
          w_m_wr      = s1_wr;
          w_m_rd      = s1_rd;
          w_state_nxt = ST_DRAIN;
        end else if (!m_valid) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_any_wait) begin
          w_cnt_nxt = '0;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
        if (w_state_nxt == ST_DRAIN) begin
          w_s_valid = 1'b0;
          w_m_wait  = 1'b0;
          w_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        w_s_valid   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_s_valid   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef PCPI_DISPATCH_STATS_EN
  logic w_hit0;
  logic w_hit1;
  logic w_both;
  logic w_tmo;

  assign w_hit0 = (r_state == ST_ISSUE) && s0_ready;
  assign w_hit1 = (r_state == ST_ISSUE) && !s0_ready && s1_ready;
  assign w_both = (r_state == ST_ISSUE) && s0_ready && s1_ready;
  assign w_tmo  = (r_state == ST_ISSUE) && !s0_ready && !s1_ready && m_valid &&
                  !w_any_wait && (w_cnt_inc == CNT_W'(TIMEOUT));

  // Saturating event counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_s0      <= '0;
      stat_s1      <= '0;
      stat_timeout <= '0;
      stat_collide <= '0;
    end else begin
      if (w_hit0 && (stat_s0 != '1))      stat_s0      <= stat_s0 + 16'd1;
      if (w_hit1 && (stat_s1 != '1))      stat_s1      <= stat_s1 + 16'd1;
      if (w_tmo  && (stat_timeout != '1)) stat_timeout <= stat_timeout + 8'd1;
      if (w_both && (stat_collide != '1)) stat_collide <= stat_collide + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Randomised self-checking bench for pcpi_dispatch; expected timing and results come from per-transaction plans.
module tb_pcpi_dispatch;

  localparam int TIMEOUT = 16;
  localparam int K_S0 = 0, K_S1 = 1, K_BOTH = 2, K_TO = 3, K_ABN = 4, K_LWAIT = 5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid;
  logic [31:0] m_insn, m_rs1, m_rs2;
  logic        m_wr, m_wait, m_ready, s_valid;
  logic [31:0] m_rd, s_insn, s_rs1, s_rs2;
  logic        s0_wr, s0_ready, s0_wait, s1_wr, s1_ready, s1_wait;
  logic [31:0] s0_rd, s1_rd;
`ifdef PCPI_DISPATCH_STATS_EN
  logic [15:0] stat_s0, stat_s1;
  logic [7:0]  stat_timeout, stat_collide;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int e_s0 = 0, e_s1 = 0, e_to = 0, e_col = 0;

  pcpi_dispatch #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_insn(m_insn), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_wr(m_wr), .m_rd(m_rd), .m_wait(m_wait), .m_ready(m_ready),
    .s_valid(s_valid), .s_insn(s_insn), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s0_wr(s0_wr), .s0_ready(s0_ready), .s0_wait(s0_wait), .s0_rd(s0_rd),
    .s1_wr(s1_wr), .s1_ready(s1_ready), .s1_wait(s1_wait), .s1_rd(s1_rd)
`ifdef PCPI_DISPATCH_STATS_EN
    , .stat_s0(stat_s0), .stat_s1(stat_s1),
    .stat_timeout(stat_timeout), .stat_collide(stat_collide)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic idle_slaves();
    s0_wr = 1'b0; s0_ready = 1'b0; s0_wait = 1'b0; s0_rd = $urandom;
    s1_wr = 1'b0; s1_ready = 1'b0; s1_wait = 1'b0; s1_rd = $urandom;
  endtask

  task automatic test_reset();
    resetn = 1'b1; m_valid = 1'b0; m_insn = '0; m_rs1 = '0; m_rs2 = '0;
    idle_slaves();
    #1 resetn = 1'b0;
    #2;
    n_checks++;
    if ({m_wr, m_wait, m_ready, s_valid, m_rd, s_insn, s_rs1, s_rs2} !== 132'd0) begin
      n_errors++;
      $display("FAIL reset_state got %h expected 0", {m_wr, m_wait, m_ready, s_valid, m_rd, s_insn, s_rs1, s_rs2});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // One transaction; kind selects how the slaves behave, p1 is the latency / wait length
  task automatic run_txn(input int kind, input int p1, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] rd1);
    int          term;
    logic        exp_rdy, exp_wr, wr0, wr1, prevw;
    logic        w0, w1, r0, r1, mv;
    logic [31:0] exp_rd, insn;
    insn = $urandom;
    wr0  = 1'($urandom);
    wr1  = 1'($urandom);
    case (kind)
      K_TO:    term = p1 + TIMEOUT;
      K_LWAIT: term = p1 + 1;
      default: term = p1;
    endcase
    exp_rdy = (kind != K_TO) && (kind != K_ABN);
    exp_wr  = exp_rdy && ((kind == K_S1) ? wr1 : wr0);
    exp_rd  = !exp_rdy ? 32'd0 : ((kind == K_S1) ? rd1 : rs1 * rs2);
    m_valid = 1'b1; m_insn = insn; m_rs1 = rs1; m_rs2 = rs2;
    @(posedge clk); #1;
    prevw = 1'b0;
    for (int j = 1; j <= term; j++) begin
      n_checks++;
      if ({s_valid, m_ready, m_wr, m_wait, m_rd, s_insn, s_rs1, s_rs2} !==
          {1'b1, 1'b0, 1'b0, prevw, 32'd0, insn, rs1, rs2}) begin
        n_errors++;
        $display("FAIL issue_k%0d_c%0d got %h expected %h", kind, j,
                 {s_valid, m_ready, m_wr, m_wait, m_rd, s_insn, s_rs1, s_rs2},
                 {1'b1, 1'b0, 1'b0, prevw, 32'd0, insn, rs1, rs2});
      end
      w0 = 1'b0; w1 = 1'b0; r0 = 1'b0; r1 = 1'b0; mv = 1'b1;
      if (j < term) begin
        case (kind)
          K_LWAIT: w0 = 1'b1;
          K_TO:    if (j <= p1) begin w0 = 1'b1; w1 = 1'($urandom); end
          default: begin w0 = 1'($urandom); w1 = 1'($urandom); end
        endcase
      end else begin
        case (kind)
          K_S0, K_LWAIT: r0 = 1'b1;
          K_S1:          r1 = 1'b1;
          K_BOTH:        begin r0 = 1'b1; r1 = 1'b1; end
          K_ABN:         mv = 1'b0;
          default:       ;
        endcase
      end
      m_valid  = mv;
      m_insn   = $urandom; m_rs1 = $urandom; m_rs2 = $urandom;
      s0_wait  = w0; s1_wait = w1; s0_ready = r0; s1_ready = r1;
      s0_wr    = r0 ? wr0 : 1'($urandom);
      s1_wr    = r1 ? wr1 : 1'($urandom);
      s0_rd    = r0 ? s_rs1 * s_rs2 : $urandom;
      s1_rd    = r1 ? rd1 : $urandom;
      prevw    = w0 | w1;
      @(posedge clk); #1;
    end
    n_checks++;
    if ({s_valid, m_wait, m_ready, m_wr, m_rd} !== {1'b0, 1'b0, exp_rdy, exp_wr, exp_rd}) begin
      n_errors++;
      $display("FAIL drain_k%0d got %h expected %h", kind,
               {s_valid, m_wait, m_ready, m_wr, m_rd}, {1'b0, 1'b0, exp_rdy, exp_wr, exp_rd});
    end
    m_valid = 1'($urandom);
    idle_slaves();
    @(posedge clk); #1;
    n_checks++;
    if ({s_valid, m_wait, m_ready, m_wr, m_rd} !== 36'd0) begin
      n_errors++;
      $display("FAIL idle_after_k%0d got %h expected 0", kind, {s_valid, m_wait, m_ready, m_wr, m_rd});
    end
    m_valid = 1'b0;
    case (kind)
      K_S0, K_LWAIT: e_s0++;
      K_S1:          e_s1++;
      K_BOTH:        begin e_s0++; e_col++; end
      K_TO:          e_to++;
      default:       ;
    endcase
  endtask

  task automatic test_s0_basic();   run_txn(K_S0, 4, 32'h3, 32'h5, 32'h0);                  endtask
  task automatic test_timeout();    run_txn(K_TO, 0, $urandom, $urandom, 32'h0);           endtask
  task automatic test_long_wait();  run_txn(K_LWAIT, 40, 32'h12345678, 32'h1, 32'h0);      endtask
  task automatic test_collide();    run_txn(K_BOTH, 2, 32'h0000AAAA, 32'h1, 32'h00005555); endtask

  task automatic test_abandon();
    run_txn(K_ABN, 3, $urandom, $urandom, 32'h0);
    run_txn(K_S1, 2, $urandom, $urandom, $urandom);
  endtask

  task automatic test_random();
    int kind, p1;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        K_TO:    p1 = $urandom_range(0, 3);
        K_ABN:   p1 = $urandom_range(1, 8);
        K_LWAIT: p1 = $urandom_range(16, 30);
        default: p1 = $urandom_range(1, 10);
      endcase
      run_txn(kind, p1, $urandom, $urandom, $urandom);
    end
  endtask

  task automatic test_reset_mid();
    m_valid = 1'b1; m_insn = $urandom; m_rs1 = $urandom; m_rs2 = $urandom;
    @(posedge clk); #1;
    s0_wait = 1'b1;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    n_checks++;
    if ({m_wr, m_wait, m_ready, s_valid, m_rd, s_insn, s_rs1, s_rs2} !== 132'd0) begin
      n_errors++;
      $display("FAIL reset_mid got %h expected 0", {m_wr, m_wait, m_ready, s_valid, m_rd, s_insn, s_rs1, s_rs2});
    end
`ifdef PCPI_DISPATCH_STATS_EN
    e_s0 = 0; e_s1 = 0; e_to = 0; e_col = 0;
`endif
    m_valid = 1'b0; s0_wait = 1'b0; s0_ready = 1'b1; s0_rd = $urandom;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({m_ready, m_wr, s_valid} !== 3'b000) begin
        n_errors++;
        $display("FAIL post_reset_c%0d got %b expected 000", k, {m_ready, m_wr, s_valid});
      end
    end
    idle_slaves();
    run_txn(K_S0, 1, $urandom, $urandom, 32'h0);
  endtask

  task automatic test_stats();
`ifdef PCPI_DISPATCH_STATS_EN
    n_checks++;
    if ({stat_s0, stat_s1, stat_timeout, stat_collide} !==
        {16'(e_s0), 16'(e_s1), 8'(e_to), 8'(e_col)}) begin
      n_errors++;
      $display("FAIL stats got %h expected %h", {stat_s0, stat_s1, stat_timeout, stat_collide},
               {16'(e_s0), 16'(e_s1), 8'(e_to), 8'(e_col)});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_s0_basic();
    test_timeout();
    test_long_wait();
    test_collide();
    test_abandon();
    test_random();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
